conv3x3_mac: RTL and testbench
==============================

// Module: conv3x3_mac
// PURPOSE
//  Downstream of the 3x3 window generator: takes one 3x3 window of unsigned pixels per win_valid,
//  computes the dot product with a loaded signed 3x3 kernel, adds bias, then shifts, activates and
//  saturates the result to an output pixel. Fully pipelined, 1 window/cycle, no backpressure.
//  Kernel and bias are loaded through a serial beat interface into a shadow bank, then committed atomically.
// PARAMETERS
//  DATA_W  8   pixel width, unsigned, in and out
//  WT_W    8   kernel tap width, signed
//  BIAS_W  16  bias width, signed; also the width of wt_data
//  ACC_W   24  accumulator width, signed; must be >= DATA_W+WT_W+5
//  SHIFT   7   arithmetic right shift applied before activation (0..ACC_W-2)
// PORTS
//  clk        in   1       clock
//  rst        in   1       synchronous, active-high reset
//  win_valid  in   1       w0..w8 valid this cycle
//  w0..w8     in   DATA_W  window pixels, row-major; w0 = top-left, w8 = bottom-right
//  wt_start   in   1       pulse: begin (or restart) a kernel load
//  wt_valid   in   1       wt_data beat valid
//  wt_data    in   BIAS_W  beats 0-8: tap k0..k8 in [WT_W-1:0]; beat 9: bias in full width
//  out_valid  out  1       out_data valid
//  out_data   out  DATA_W  convolved pixel
//  weights_ok out  1       a complete kernel has been committed since reset
//  wt_done    out  1       1-cycle pulse on the commit cycle
//  drop_err   out  1       sticky: a window arrived while weights_ok=0
// BEHAVIOUR
//  Reset: all outputs 0; active/shadow taps and bias 0; pipeline valids cleared; FSM = IDLE; beat idx 0.
//  Load FSM has two states, IDLE and LOAD.
//   - IDLE: wt_start -> LOAD, idx <= 0. wt_valid is ignored.
//   - LOAD: wt_valid writes shadow[idx] and increments idx.
//   - LOAD: wt_start restarts at idx 0 and wins over a coincident wt_valid.
//   - Beat 9 (bias) commits shadow -> active in one cycle: wt_done=1, weights_ok<=1, -> IDLE.
//  Commit timing: windows accepted on the commit cycle use the old kernel; windows from the next cycle use the new one.
//  Windows keep streaming during LOAD and use the active bank.
//  A window is accepted when win_valid=1 and weights_ok=1.
//   - With weights_ok=0 it is discarded: no out_valid, drop_err<=1 (cleared only by rst).
//  Pipeline, latency 4 (window accepted at cycle N -> out_valid at cycle N+4). No bubbles; gaps pass through.
//   S1: 9 products, pixel zero-extended to DATA_W+1 signed, times the tap.
//   S2: three row sums.
//   S3: total + sign-extended bias -> ACC_W.
//   S4: arithmetic >>> SHIFT (floor), then activation/saturation.
//   The bias value travels with its window so that a commit cannot mix kernels within one result.
//  Accumulator never overflows, given the ACC_W constraint.
//  out_data holds its last value when out_valid=0.
//  Reset mid-stream flushes the pipeline; no out_valid for windows in flight.
//  Reset mid-load discards the shadow bank, and weights_ok returns to 0.
// CONFIGURATION
//  CONV_RELU_EN defined:
//   - ReLU: shifted value <0 -> 0; >2^DATA_W-1 -> 2^DATA_W-1.
//   - out_data is unsigned.
//  CONV_RELU_EN undefined:
//   - signed saturation to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
//   - out_data is a two's-complement bit pattern.
// STRUCTURE
//  Package cnn_pkg holds:
//   - DATA_W/WT_W/BIAS_W/ACC_W defaults
//   - KERNEL_TAPS=9, LOAD_BEATS=10
//   - load FSM state enum {IDLE, LOAD}
//  Sub-module conv_requant is the S4 stage: shift, activation and saturation, registered, shared by later layers.
//  Everything else stays in conv3x3_mac.
// TESTING (bench instance SHIFT=0 unless noted)
//  1. Identity: taps 0 except k4=1, bias 0; window w4=200 -> out_data=200 exactly 4 cycles after win_valid.
//  2. Stream: 20 back-to-back windows with k4=1 -> 20 consecutive out_valid, values in order; a 1-cycle win_valid gap -> matching 1-cycle gap.
//  3. Activation: all taps -1, bias 0, all pixels 10 -> sum -90.
//     ReLU build: out_data=0. Non-ReLU build: out_data=8'hA6.
//     Then taps +1, pixels 255 -> 2295: out_data=255 (ReLU) / 127 (non-ReLU).
//  4. SHIFT=7: taps 127, bias 1000, pixels 1 -> (1143+1000)>>>7 = 16.
//     Bias -2000 -> floor(-857/128) = -7 -> ReLU build out_data=0.
//  5. Load edges:
//     - win_valid before any load -> no output, drop_err=1.
//     - wt_start at beat 5 restarts the load.
//     - Stream windows across a commit: results before/after the commit cycle use old/new kernel, none mixed.
//  6. Reset: assert rst with 3 windows in flight -> no out_valid afterwards; weights_ok=0, drop_err=0.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath blocks: default widths, kernel geometry, load FSM states.
package cnn_pkg;

   localparam int unsigned CNN_DATA_W  = 8;
   localparam int unsigned CNN_WT_W    = 8;
   localparam int unsigned CNN_BIAS_W  = 16;
   localparam int unsigned CNN_ACC_W   = 24;
   localparam int unsigned CNN_SHIFT   = 7;

   localparam int unsigned KERNEL_TAPS = 9;
   localparam int unsigned LOAD_BEATS  = 10;

   typedef enum logic {
      IDLE = 1'b0,
      LOAD = 1'b1
   } load_state_e;

endpackage

// File: rtl/conv_requant.sv
// Requantisation stage: arithmetic right shift, activation and saturation to DATA_W, registered.
// Build option CONV_RELU_EN: defined -> ReLU clamp to [0, 2^DATA_W-1];
// undefined -> signed clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1], two's-complement output.
module conv_requant #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ACC_W  = 24,
   parameter int unsigned SHIFT  = 7
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic signed [ACC_W-1:0] in_acc,
   output logic                    out_valid,
   output logic [DATA_W-1:0]       out_data
);

`ifdef CONV_RELU_EN
   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** DATA_W) - 1);
   localparam logic signed [ACC_W-1:0] SAT_LO = '0;
`else
   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2 ** (DATA_W - 1)));
`endif

   logic                    out_valid_q, out_valid_d;
   logic [DATA_W-1:0]       out_data_q, out_data_d;
   logic signed [ACC_W-1:0] shifted_c;

   // Floor shift, then clamp; data holds its last value when no result arrives.
   always_comb begin
      shifted_c   = in_acc >>> SHIFT;
      out_valid_d = in_valid;
      out_data_d  = out_data_q;
      if (in_valid) begin
         if (shifted_c < SAT_LO) begin
            out_data_d = SAT_LO[DATA_W-1:0];
         end else if (shifted_c > SAT_HI) begin
            out_data_d = SAT_HI[DATA_W-1:0];
         end else begin
            out_data_d = shifted_c[DATA_W-1:0];
         end
      end
   end

   // Output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: rtl/conv3x3_mac.sv
// 3x3 convolution MAC: signed kernel and bias loaded serially into a shadow bank and committed
// atomically; windows stream through a 4-stage pipeline (products, row sums, total+bias, requant).
// Activation is selected by the CONV_RELU_EN build macro inside conv_requant.
module conv3x3_mac
   import cnn_pkg::*;
#(
   parameter int unsigned DATA_W = CNN_DATA_W,
   parameter int unsigned WT_W   = CNN_WT_W,
   parameter int unsigned BIAS_W = CNN_BIAS_W,
   parameter int unsigned ACC_W  = CNN_ACC_W,
   parameter int unsigned SHIFT  = CNN_SHIFT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              win_valid,
   input  logic [DATA_W-1:0] w0,
   input  logic [DATA_W-1:0] w1,
   input  logic [DATA_W-1:0] w2,
   input  logic [DATA_W-1:0] w3,
   input  logic [DATA_W-1:0] w4,
   input  logic [DATA_W-1:0] w5,
   input  logic [DATA_W-1:0] w6,
   input  logic [DATA_W-1:0] w7,
   input  logic [DATA_W-1:0] w8,
   input  logic              wt_start,
   input  logic              wt_valid,
   input  logic [BIAS_W-1:0] wt_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              weights_ok,
   output logic              wt_done,
   output logic              drop_err
);

   localparam int unsigned PROD_W = DATA_W + WT_W + 1;
   localparam int unsigned ROW_W  = PROD_W + 2;
   localparam int unsigned IDX_W  = $clog2(LOAD_BEATS);

   logic [KERNEL_TAPS-1:0][DATA_W-1:0] win_c;
   assign win_c = {w8, w7, w6, w5, w4, w3, w2, w1, w0};

   // Load FSM and kernel banks
   load_state_e                      state_q, state_d;
   logic [IDX_W-1:0]                 idx_q, idx_d;
   logic [KERNEL_TAPS-1:0][WT_W-1:0] shadow_q, shadow_d;
   logic [KERNEL_TAPS-1:0][WT_W-1:0] act_tap_q, act_tap_d;
   logic signed [BIAS_W-1:0]         act_bias_q, act_bias_d;
   logic                             weights_ok_q, weights_ok_d;
   logic                             wt_done_q, wt_done_d;
   logic                             drop_err_q, drop_err_d;

   // Pipeline registers
   logic                     s1_valid_q, s1_valid_d;
   logic signed [PROD_W-1:0] s1_prod_q [KERNEL_TAPS];
   logic signed [PROD_W-1:0] s1_prod_d [KERNEL_TAPS];
   logic signed [BIAS_W-1:0] s1_bias_q, s1_bias_d;
   logic                     s2_valid_q, s2_valid_d;
   logic signed [ROW_W-1:0]  s2_row_q [3];
   logic signed [ROW_W-1:0]  s2_row_d [3];
   logic signed [BIAS_W-1:0] s2_bias_q, s2_bias_d;
   logic                     s3_valid_q, s3_valid_d;
   logic signed [ACC_W-1:0]  s3_acc_q, s3_acc_d;

   // Kernel load sequencing; beat 9 carries the bias and commits the shadow taps in the same cycle.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      shadow_d     = shadow_q;
      act_tap_d    = act_tap_q;
      act_bias_d   = act_bias_q;
      weights_ok_d = weights_ok_q;
      wt_done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (wt_start) begin
               state_d = LOAD;
               idx_d   = '0;
            end
         end
         LOAD: begin
            if (wt_start) begin
               idx_d = '0;
            end else if (wt_valid) begin
               if (idx_q == IDX_W'(LOAD_BEATS - 1)) begin
                  act_tap_d    = shadow_q;
                  act_bias_d   = wt_data;
                  weights_ok_d = 1'b1;
                  wt_done_d    = 1'b1;
                  state_d      = IDLE;
                  idx_d        = '0;
               end else begin
                  shadow_d[idx_q] = wt_data[WT_W-1:0];
                  idx_d           = idx_q + IDX_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath stages S1..S3; the bias rides along with its window so a commit never splits a result.
   always_comb begin
      s1_valid_d = win_valid & weights_ok_q;
      s1_bias_d  = act_bias_q;
      for (int unsigned i = 0; i < KERNEL_TAPS; i++) begin
         s1_prod_d[i] = PROD_W'($signed({1'b0, win_c[i]})) * PROD_W'($signed(act_tap_q[i]));
      end
      s2_valid_d = s1_valid_q;
      s2_bias_d  = s1_bias_q;
      for (int unsigned r = 0; r < 3; r++) begin
         s2_row_d[r] = ROW_W'(s1_prod_q[3*r]) + ROW_W'(s1_prod_q[3*r+1]) + ROW_W'(s1_prod_q[3*r+2]);
      end
      s3_valid_d = s2_valid_q;
      s3_acc_d   = ACC_W'(s2_row_q[0]) + ACC_W'(s2_row_q[1]) + ACC_W'(s2_row_q[2]) + ACC_W'(s2_bias_q);
      drop_err_d = drop_err_q | (win_valid & ~weights_ok_q);
   end

   // State and pipeline registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         shadow_q     <= '0;
         act_tap_q    <= '0;
         act_bias_q   <= '0;
         weights_ok_q <= 1'b0;
         wt_done_q    <= 1'b0;
         drop_err_q   <= 1'b0;
         s1_valid_q   <= 1'b0;
         s1_bias_q    <= '0;
         s2_valid_q   <= 1'b0;
         s2_bias_q    <= '0;
         s3_valid_q   <= 1'b0;
         s3_acc_q     <= '0;
         for (int unsigned i = 0; i < KERNEL_TAPS; i++) s1_prod_q[i] <= '0;
         for (int unsigned r = 0; r < 3; r++) s2_row_q[r] <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         shadow_q     <= shadow_d;
         act_tap_q    <= act_tap_d;
         act_bias_q   <= act_bias_d;
         weights_ok_q <= weights_ok_d;
         wt_done_q    <= wt_done_d;
         drop_err_q   <= drop_err_d;
         s1_valid_q   <= s1_valid_d;
         s1_bias_q    <= s1_bias_d;
         s2_valid_q   <= s2_valid_d;
         s2_bias_q    <= s2_bias_d;
         s3_valid_q   <= s3_valid_d;
         s3_acc_q     <= s3_acc_d;
         for (int unsigned i = 0; i < KERNEL_TAPS; i++) s1_prod_q[i] <= s1_prod_d[i];
         for (int unsigned r = 0; r < 3; r++) s2_row_q[r] <= s2_row_d[r];
      end
   end

   // S4: shift, activation, saturation.
   conv_requant #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .SHIFT  (SHIFT)
   ) u_requant (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (s3_valid_q),
      .in_acc    (s3_acc_q),
      .out_valid (out_valid),
      .out_data  (out_data)
   );

   assign weights_ok = weights_ok_q;
   assign wt_done    = wt_done_q;
   assign drop_err   = drop_err_q;

endmodule

// File: tb/tb_conv3x3_mac.sv
// Directed bench for conv3x3_mac: two instances (SHIFT=0 and SHIFT=7) share all stimulus.
module tb_conv3x3_mac;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        win_valid = 1'b0;
   logic [7:0]  w [9];
   logic        wt_start = 1'b0;
   logic        wt_valid = 1'b0;
   logic [15:0] wt_data = '0;

   logic       ov0, ov7, ok0, ok7, dn0, dn7, de0, de7;
   logic [7:0] od0, od7;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   conv3x3_mac #(.DATA_W(8), .WT_W(8), .BIAS_W(16), .ACC_W(24), .SHIFT(0)) u_s0 (
      .clk(clk), .rst(rst), .win_valid(win_valid),
      .w0(w[0]), .w1(w[1]), .w2(w[2]), .w3(w[3]), .w4(w[4]), .w5(w[5]), .w6(w[6]), .w7(w[7]), .w8(w[8]),
      .wt_start(wt_start), .wt_valid(wt_valid), .wt_data(wt_data),
      .out_valid(ov0), .out_data(od0), .weights_ok(ok0), .wt_done(dn0), .drop_err(de0));

   conv3x3_mac #(.DATA_W(8), .WT_W(8), .BIAS_W(16), .ACC_W(24), .SHIFT(7)) u_s7 (
      .clk(clk), .rst(rst), .win_valid(win_valid),
      .w0(w[0]), .w1(w[1]), .w2(w[2]), .w3(w[3]), .w4(w[4]), .w5(w[5]), .w6(w[6]), .w7(w[7]), .w8(w[8]),
      .wt_start(wt_start), .wt_valid(wt_valid), .wt_data(wt_data),
      .out_valid(ov7), .out_data(od7), .weights_ok(ok7), .wt_done(dn7), .drop_err(de7));

   typedef struct {
      int k [9];
      int bias;
      int p [9];
      int e0r;   // SHIFT=0, ReLU build
      int e0s;   // SHIFT=0, signed build (8-bit pattern)
      int e7r;   // SHIFT=7, ReLU build
      int e7s;   // SHIFT=7, signed build
   } vec_t;

   vec_t vecs [11];

   // Per-cycle stream stimulus and expectations
   logic        s_win [40];
   int          s_pix [40];
   int          s_exp [40];
   logic        s_st  [40];
   logic        s_wv  [40];
   logic [15:0] s_wd  [40];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic load_kernel(input int k [9], input int bias);
      wt_start = 1'b1;
      tick();
      wt_start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         wt_valid = 1'b1;
         wt_data  = (i < 9) ? 16'(k[i]) : 16'(bias);
         tick();
      end
      wt_valid = 1'b0;
      wt_data  = '0;
   endtask

   task automatic count_out(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         if (ov0 || ov7) cnt++;
         tick();
      end
   endtask

   task automatic clear_stream();
      for (int c = 0; c < 40; c++) begin
         s_win[c] = 1'b0; s_pix[c] = 0; s_exp[c] = 0;
         s_st[c] = 1'b0; s_wv[c] = 1'b0; s_wd[c] = '0;
      end
   endtask

   // Applies s_* for n cycles; the window driven in cycle c must appear after the 4th following edge.
   task automatic run_stream(input int n, input string tag);
      for (int c = 0; c < n + 4; c++) begin
         if (c < n) begin
            win_valid = s_win[c];
            for (int j = 0; j < 9; j++) w[j] = 8'($urandom_range(0, 255));
            w[4]     = 8'(s_pix[c]);
            wt_start = s_st[c];
            wt_valid = s_wv[c];
            wt_data  = s_wd[c];
         end else begin
            win_valid = 1'b0; wt_start = 1'b0; wt_valid = 1'b0; wt_data = '0;
         end
         tick();
         if (c >= 3 && (c - 3) < n && s_win[c-3]) begin
            chk({tag, "_valid"}, int'(ov0), 1);
            chk({tag, "_data"}, int'(od0), s_exp[c-3]);
         end else begin
            chk({tag, "_gap"}, int'(ov0), 0);
         end
      end
   endtask

   int   cnt;
   int   exp0, exp7;
   int   kid [9];

   initial begin
      for (int j = 0; j < 9; j++) w[j] = '0;
      //            taps                                 bias    pixels                                   e0r  e0s  e7r  e7s
      vecs[0]  = '{'{0,0,0,0,1,0,0,0,0},                 0,     '{50,50,50,50,200,50,50,50,50},          200, 127, 1,   1};
      vecs[1]  = '{'{-1,-1,-1,-1,-1,-1,-1,-1,-1},        0,     '{10,10,10,10,10,10,10,10,10},           0,   166, 0,   255};
      vecs[2]  = '{'{1,1,1,1,1,1,1,1,1},                 0,     '{255,255,255,255,255,255,255,255,255},  255, 127, 17,  17};
      vecs[3]  = '{'{127,127,127,127,127,127,127,127,127}, 1000, '{1,1,1,1,1,1,1,1,1},                  255, 127, 16,  16};
      vecs[4]  = '{'{127,127,127,127,127,127,127,127,127}, -2000, '{1,1,1,1,1,1,1,1,1},                 0,   128, 0,   249};
      vecs[5]  = '{'{1,-1,0,0,0,0,0,0,2},                5,     '{1,2,3,4,5,6,7,8,9},                    22,  22,  0,   0};
      vecs[6]  = '{'{-128,0,0,0,0,0,0,0,0},              32767, '{255,7,7,7,7,7,7,7,7},                  127, 127, 0,   0};
      vecs[7]  = '{'{0,0,0,0,0,0,0,0,0},                 -1,    '{9,9,9,9,9,9,9,9,9},                    0,   255, 0,   255};
      vecs[8]  = '{'{0,0,0,0,1,0,0,0,0},                 0,     '{0,0,0,0,128,0,0,0,0},                  128, 127, 1,   1};
      vecs[9]  = '{'{0,0,0,0,0,0,0,0,0},                 -129,  '{3,3,3,3,3,3,3,3,3},                    0,   128, 0,   254};
      vecs[10] = '{'{-128,-128,-128,-128,-128,-128,-128,-128,-128}, 0, '{255,255,255,255,255,255,255,255,255}, 0, 128, 0, 128};

      // Reset state
      tick(); tick();
      rst = 1'b0;
      chk("rst_out_valid", int'(ov0 | ov7), 0);
      chk("rst_out_data", int'(od0 | od7), 0);
      chk("rst_weights_ok", int'(ok0 | ok7), 0);
      chk("rst_wt_done", int'(dn0 | dn7), 0);
      chk("rst_drop_err", int'(de0 | de7), 0);

      // Window before any kernel: discarded, drop_err set
      w[4] = 8'd77;
      win_valid = 1'b1;
      tick();
      win_valid = 1'b0;
      count_out(6, cnt);
      chk("drop_no_output", cnt, 0);
      chk("drop_err_set", int'(de0 & de7), 1);

      // Identity load, commit pulse
      for (int j = 0; j < 9; j++) kid[j] = (j == 4) ? 1 : 0;
      load_kernel(kid, 0);
      chk("commit_wt_done", int'(dn0 & dn7), 1);
      chk("commit_weights_ok", int'(ok0 & ok7), 1);
      tick();
      chk("wt_done_pulse_end", int'(dn0 | dn7), 0);
      chk("weights_ok_held", int'(ok0 & ok7), 1);

      // Exact latency: out_valid only on the 4th edge after the window
      for (int j = 0; j < 9; j++) w[j] = 8'd33;
      w[4] = 8'd100;
      win_valid = 1'b1;
      tick();
      win_valid = 1'b0;
      chk("lat_edge1", int'(ov0), 0);
      tick();
      chk("lat_edge2", int'(ov0), 0);
      tick();
      chk("lat_edge3", int'(ov0), 0);
      tick();
      chk("lat_edge4_valid", int'(ov0), 1);
      chk("lat_edge4_data", int'(od0), 100);
      tick();
      chk("lat_edge5_valid", int'(ov0), 0);
      chk("lat_hold_data", int'(od0), 100);

      // Back-to-back stream of 20 windows with a 1-cycle gap after the 10th
      clear_stream();
      begin
         int n = 0;
         for (int c = 0; c < 21; c++) begin
            if (c != 10) begin
               s_win[c] = 1'b1;
               s_pix[c] = 3 + 5 * n;
               s_exp[c] = 3 + 5 * n;
               n++;
            end
         end
      end
      run_stream(21, "stream");

      // Reload during streaming with a restart at beat 5; commit cycle 16 still uses the old kernel
      clear_stream();
      s_st[0] = 1'b1;
      for (int b = 0; b < 5; b++) begin
         s_wv[1+b] = 1'b1;
         s_wd[1+b] = (b == 4) ? 16'd5 : 16'd0;
      end
      s_st[6] = 1'b1; s_wv[6] = 1'b1; s_wd[6] = 16'h0033;
      for (int b = 0; b < 10; b++) begin
         s_wv[7+b] = 1'b1;
         s_wd[7+b] = (b == 4) ? 16'd2 : 16'd0;
      end
      for (int c = 0; c < 22; c++) begin
         s_win[c] = 1'b1;
         s_pix[c] = 10 + c;
         s_exp[c] = (c <= 16) ? (10 + c) : 2 * (10 + c);
      end
      run_stream(22, "commit");
      chk("commit_ok_after", int'(ok0), 1);

      // Table of single windows, both shift settings
      for (int v = 0; v < 11; v++) begin
         load_kernel(vecs[v].k, vecs[v].bias);
         for (int j = 0; j < 9; j++) w[j] = 8'(vecs[v].p[j]);
         win_valid = 1'b1;
         tick();
         win_valid = 1'b0;
         tick(); tick(); tick();
`ifdef CONV_RELU_EN
         exp0 = vecs[v].e0r;
         exp7 = vecs[v].e7r;
`else
         exp0 = vecs[v].e0s;
         exp7 = vecs[v].e7s;
`endif
         chk($sformatf("vec%0d_s0_valid", v), int'(ov0), 1);
         chk($sformatf("vec%0d_s0_data", v), int'(od0), exp0);
         chk($sformatf("vec%0d_s7_valid", v), int'(ov7), 1);
         chk($sformatf("vec%0d_s7_data", v), int'(od7), exp7);
      end

      // Reset with three windows in flight
      for (int c = 0; c < 3; c++) begin
         w[4] = 8'(40 + c);
         win_valid = 1'b1;
         tick();
      end
      win_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      count_out(6, cnt);
      chk("flush_no_output", cnt, 0);
      chk("flush_weights_ok", int'(ok0 | ok7), 0);
      chk("flush_drop_err", int'(de0 | de7), 0);
      chk("flush_out_data", int'(od0), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard stop if the sequence ever stalls
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
